pc_branch_sequencer: RTL and testbench

- Owns the program counter and instruction-fetch sequencing for the processor core.
- Resolves the branch condition from ALU flags and produces the branch-taken select that drives the next-PC mux.
- Computes and commits the next PC after each instruction.
- Sits between the instruction memory port and the decode/ALU stage, and consumes the branch/jump control decoded from each instruction.

---
 rtl/pc_branch_sequencer.sv | 117 +++++++++++
 tb/tb_pc_branch_sequencer.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pc_branch_sequencer.sv
// Program counter, fetch handshake and branch resolution for the core.
// Define BRANCH_STATS_EN to add the saturating taken_count redirect counter.
module pc_branch_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          XLEN     = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   output logic            inst_valid,
   input  logic            branch,
   input  logic            jump,
   input  logic            jalr,
   input  logic [2:0]      funct3,
   input  logic            alu_zero,
   input  logic            alu_lt,
   input  logic            alu_ltu,
   input  logic [XLEN-1:0] branch_target,
   input  logic [XLEN-1:0] jalr_target,
   output logic            branch_taken,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4
`ifdef BRANCH_STATS_EN
   ,
   output logic [31:0]     taken_count
`endif
);

   localparam logic [1:0] S_BOOT  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_EXEC  = 2'd2;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] next_pc;
   logic            cond;
   logic            commit;

   assign imem_req   = (state_q == S_FETCH);
   assign inst_valid = (state_q == S_EXEC);
   assign imem_addr  = pc_q;
   assign pc         = pc_q;
   assign pc_plus4   = pc_q + 32'd4;
   assign commit     = inst_valid & ~stall;

   always_comb begin
      cond = 1'b0;
      case (funct3)
         3'b000:  cond = alu_zero;
         3'b001:  cond = ~alu_zero;
         3'b100:  cond = alu_lt;
         3'b101:  cond = ~alu_lt;
         3'b110:  cond = alu_ltu;
         3'b111:  cond = ~alu_ltu;
         default: cond = 1'b0;
      endcase
   end

   assign branch_taken = inst_valid & (jalr | jump | (branch & cond));

   always_comb begin
      if (jalr)
         next_pc = {jalr_target[XLEN-1:1], 1'b0};
      else if (jump || (branch && cond))
         next_pc = branch_target;
      else
         next_pc = pc_plus4;
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      case (state_q)
         S_BOOT:  state_d = S_FETCH;
         S_FETCH: if (imem_ack) state_d = S_EXEC;
         S_EXEC: begin
            if (!stall) begin
               state_d = S_FETCH;
               // committed PCs are always word aligned
               pc_d    = {next_pc[XLEN-1:2], 2'b00};
            end
         end
         default: state_d = S_BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (commit && branch_taken && (cnt_q != 32'hFFFF_FFFF))
         cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= 32'd0;
      else        cnt_q <= cnt_d;
   end

   assign taken_count = cnt_q;
`endif

endmodule

// File: tb/tb_pc_branch_sequencer.sv
// Directed, table-driven bench for pc_branch_sequencer.
module tb_pc_branch_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic        inst_valid;
   logic        branch, jump, jalr;
   logic [2:0]  funct3;
   logic        alu_zero, alu_lt, alu_ltu;
   logic [31:0] branch_target, jalr_target;
   logic        branch_taken;
   logic [31:0] pc, pc_plus4;
`ifdef BRANCH_STATS_EN
   logic [31:0] taken_count;
`endif

   always #5 clk = ~clk;

   pc_branch_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .inst_valid(inst_valid), .branch(branch), .jump(jump), .jalr(jalr),
      .funct3(funct3), .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
      .branch_target(branch_target), .jalr_target(jalr_target),
      .branch_taken(branch_taken), .pc(pc), .pc_plus4(pc_plus4)
`ifdef BRANCH_STATS_EN
      , .taken_count(taken_count)
`endif
   );

   typedef struct {
      logic        br, jp, jr;
      logic [2:0]  f3;
      logic        z, lt, ltu;
      logic [31:0] bt, jt;
      logic        exp_taken;
      logic [31:0] exp_tgt;
   } vec_t;

   vec_t vecs[13];
   int errors = 0;
   int checks = 0;
   logic [31:0] exp_pc;
   logic [31:0] exp_cnt;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      branch = 0; jump = 0; jalr = 0; funct3 = 3'b000;
      alu_zero = 0; alu_lt = 0; alu_ltu = 0;
      branch_target = 32'h0; jalr_target = 32'h0;
   endtask

   initial begin
      //          br jp jr f3      z  lt ltu bt            jt            taken tgt
      vecs[0]  = '{1, 0, 0, 3'b001, 0, 0, 0, 32'h0000_0100, 32'h0,         1, 32'h0000_0100};
      vecs[1]  = '{1, 0, 0, 3'b001, 1, 0, 0, 32'h0000_0200, 32'h0,         0, 32'h0};
      vecs[2]  = '{1, 1, 1, 3'b000, 0, 0, 0, 32'h0000_0400, 32'h0000_0203, 1, 32'h0000_0200};
      vecs[3]  = '{1, 0, 0, 3'b000, 1, 0, 0, 32'h0000_0302, 32'h0,         1, 32'h0000_0300};
      vecs[4]  = '{1, 0, 0, 3'b100, 0, 1, 0, 32'h0000_0040, 32'h0,         1, 32'h0000_0040};
      vecs[5]  = '{1, 0, 0, 3'b101, 0, 1, 0, 32'h0000_0700, 32'h0,         0, 32'h0};
      vecs[6]  = '{1, 0, 0, 3'b110, 0, 0, 0, 32'h0000_0700, 32'h0,         0, 32'h0};
      vecs[7]  = '{1, 0, 0, 3'b111, 0, 0, 0, 32'h0000_0080, 32'h0,         1, 32'h0000_0080};
      vecs[8]  = '{1, 0, 0, 3'b010, 1, 1, 1, 32'h0000_0900, 32'h0,         0, 32'h0};
      vecs[9]  = '{1, 0, 0, 3'b011, 0, 0, 0, 32'h0000_0900, 32'h0,         0, 32'h0};
      vecs[10] = '{0, 1, 0, 3'b000, 0, 0, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'hFFFF_FFFC};
      vecs[11] = '{0, 0, 0, 3'b000, 0, 0, 0, 32'h0000_0500, 32'h0,         0, 32'h0};
      vecs[12] = '{1, 1, 0, 3'b000, 0, 0, 0, 32'h0000_0010, 32'h0,         1, 32'h0000_0010};

      rst_n = 0; stall = 0; imem_ack = 1; clear_ctl();
      exp_cnt = 0;
      #12;
      chk("rst_imem_req", {31'b0, imem_req}, 0);
      chk("rst_inst_valid", {31'b0, inst_valid}, 0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_taken", {31'b0, branch_taken}, 0);
`ifdef BRANCH_STATS_EN
      chk("rst_count", taken_count, 0);
`endif

      // BOOT lasts one cycle even with ack held high
      @(negedge clk) rst_n = 1;
      step();
      chk("boot_req", {31'b0, imem_req}, 1);
      chk("boot_valid", {31'b0, inst_valid}, 0);
      chk("boot_pc", pc, 32'h0);
      for (int k = 0; k < 4; k++) begin
         step();
         chk("seq_valid", {31'b0, inst_valid}, 1);
         chk("seq_taken", {31'b0, branch_taken}, 0);
         chk("seq_pc", pc, 32'(4 * k));
         chk("seq_plus4", pc_plus4, 32'(4 * k + 4));
         step();
         chk("seq_fetch_req", {31'b0, imem_req}, 1);
         chk("seq_fetch_addr", imem_addr, 32'(4 * k + 4));
      end
      exp_pc = 32'h10;

      for (int i = 0; i < 13; i++) begin
         step();
         chk("vec_valid", {31'b0, inst_valid}, 1);
         branch = vecs[i].br; jump = vecs[i].jp; jalr = vecs[i].jr;
         funct3 = vecs[i].f3; alu_zero = vecs[i].z; alu_lt = vecs[i].lt;
         alu_ltu = vecs[i].ltu; branch_target = vecs[i].bt; jalr_target = vecs[i].jt;
         #1;
         chk("vec_taken", {31'b0, branch_taken}, {31'b0, vecs[i].exp_taken});
         exp_pc = vecs[i].exp_taken ? vecs[i].exp_tgt : exp_pc + 32'd4;
         if (vecs[i].exp_taken) exp_cnt = exp_cnt + 1;
         step();
         clear_ctl();
         chk("vec_pc", pc, exp_pc);
         chk("vec_imem_addr", imem_addr, exp_pc);
         chk("vec_req", {31'b0, imem_req}, 1);
`ifdef BRANCH_STATS_EN
         chk("vec_count", taken_count, exp_cnt);
`endif
      end

      // three stalled EXEC cycles with a pending jump
      step();
      stall = 1; jump = 1; branch_target = 32'h0000_0500;
      for (int s = 0; s < 3; s++) begin
         chk("stall_valid", {31'b0, inst_valid}, 1);
         chk("stall_pc", pc, exp_pc);
`ifdef BRANCH_STATS_EN
         chk("stall_count", taken_count, exp_cnt);
`endif
         step();
      end
      chk("stall_hold_valid", {31'b0, inst_valid}, 1);
      chk("stall_hold_pc", pc, exp_pc);
      stall = 0;
      #1;
      chk("stall_taken", {31'b0, branch_taken}, 1);
      step();
      clear_ctl();
      exp_cnt = exp_cnt + 1;
      chk("stall_commit_pc", pc, 32'h0000_0500);
`ifdef BRANCH_STATS_EN
      chk("stall_commit_count", taken_count, exp_cnt);
`endif

      // delayed ack: request and address must hold
      imem_ack = 0;
      for (int w = 0; w < 4; w++) begin
         step();
         chk("wait_req", {31'b0, imem_req}, 1);
         chk("wait_valid", {31'b0, inst_valid}, 0);
         chk("wait_addr", imem_addr, 32'h0000_0500);
      end
      imem_ack = 1;
      step();
      chk("ack_valid", {31'b0, inst_valid}, 1);
      chk("ack_pc", pc, 32'h0000_0500);
      step();
      chk("ack_next_pc", pc, 32'h0000_0504);

      // async reset in the middle of a fetch
      imem_ack = 0;
      step();
      chk("pre_rst_req", {31'b0, imem_req}, 1);
      #2 rst_n = 0;
      #1;
      chk("mid_rst_req", {31'b0, imem_req}, 0);
      chk("mid_rst_pc", pc, 32'h0);
      chk("mid_rst_valid", {31'b0, inst_valid}, 0);
`ifdef BRANCH_STATS_EN
      chk("mid_rst_count", taken_count, 0);
`endif
      @(negedge clk);
      rst_n = 1; imem_ack = 1;
      step();
      chk("rerun_req", {31'b0, imem_req}, 1);
      chk("rerun_valid", {31'b0, inst_valid}, 0);
      step();
      chk("rerun_exec", {31'b0, inst_valid}, 1);
      step();
      chk("rerun_pc", pc, 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
